// File: rtl/f2h_sdram_rd_arbiter_pkg.sv
// Shared types and sizes for the f2h_sdram read arbiter slice.
// Widths are fixed here because route_t depends on the burstcount width.
package f2h_arb_pkg;
  localparam int DATA_W    = 256;
  localparam int ADDR_W    = 27;
  localparam int BURST_W   = 8;
  localparam int MAX_OUTST = 4;

  typedef enum logic {IDLE = 1'b0, CMD = 1'b1} arb_state_t;
  typedef enum logic {M0 = 1'b0, M1 = 1'b1} master_id_t;

  typedef struct packed {
    master_id_t         id;
    logic [BURST_W-1:0] beats;
  } route_t;

  function automatic master_id_t other_master(input master_id_t m);
    return (m == M0) ? M1 : M0;
  endfunction
endpackage

// File: rtl/f2h_sdram_rd_arbiter_if.sv
// Avalon-MM burst read port: master drives the command, slave returns beats.
interface f2h_sdram_rd_arbiter_if;
  import f2h_arb_pkg::*;

  logic               read;
  logic [ADDR_W-1:0]  address;
  logic [BURST_W-1:0] burstcount;
  logic               waitrequest;
  logic [DATA_W-1:0]  readdata;
  logic               readdatavalid;

  modport master (output read, address, burstcount,
                  input  waitrequest, readdata, readdatavalid);
  modport slave  (input  read, address, burstcount,
                  output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/f2h_sdram_rd_arbiter_route_fifo.sv
// In-order record of accepted bursts (issuing master + beat count).
// Head is visible combinationally so the response path adds no latency.
module rd_route_fifo
  import f2h_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTST
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  route_t                   din,
  output route_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  route_t             mem_q [DEPTH];
  route_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop) rd_d = rd_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
endmodule

// File: rtl/f2h_sdram_rd_arbiter.sv
// Shares the f2h_sdram burst read port between two masters: one command in
// flight at a time, responses routed back in issue order via rd_route_fifo.
//
// state | meaning
// IDLE  | waiting for a request while the route FIFO has room
// CMD   | registered command on s_*, waiting for s.waitrequest low
module f2h_sdram_rd_arbiter
  import f2h_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  f2h_sdram_rd_arbiter_if.slave         m0,
  f2h_sdram_rd_arbiter_if.slave         m1,
  f2h_sdram_rd_arbiter_if.master        s,
  output logic [$clog2(MAX_OUTST):0]    outstanding_o,
  output logic                          err_o
);
  arb_state_t         state_q, state_d;
  master_id_t         grant_q, grant_d, last_q, last_d, win;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] bc_q, bc_d, beat_q, beat_d, remaining;
  logic               err_q, err_d;
  logic               push, pop, full, empty;
  route_t             entry, head;

  rd_route_fifo #(.DEPTH(MAX_OUTST)) u_route_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (outstanding_o)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    addr_d    = addr_q;
    bc_d      = bc_q;
    beat_d    = beat_q;
    err_d     = err_q;
    push      = 1'b0;
    pop       = 1'b0;
    remaining = '0;
    // A zero burstcount is recorded as one beat so the route entry can retire.
    entry     = '{id: grant_q, beats: (bc_q == '0) ? BURST_W'(1) : bc_q};

    win = M0;
    if (m0.read && m1.read) win = (FIXED_PRIO != 0) ? M0 : other_master(last_q);
    else if (m1.read)       win = M1;

    case (state_q)
      IDLE: begin
        if (!full && (m0.read || m1.read)) begin
          state_d = CMD;
          grant_d = win;
          addr_d  = (win == M0) ? m0.address    : m1.address;
          bc_d    = (win == M0) ? m0.burstcount : m1.burstcount;
        end
      end
      CMD: begin
        if (!s.waitrequest) begin
          push    = 1'b1;
          last_d  = grant_q;
          state_d = IDLE;
          if (bc_q == '0) err_d = 1'b1;
        end
      end
    endcase

    // beat_q == 0 marks "no burst in progress"; the head count loads on the first beat.
    if (s.readdatavalid) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        remaining = (beat_q == '0) ? head.beats : beat_q;
        if (remaining == BURST_W'(1)) begin
          pop    = 1'b1;
          beat_d = '0;
        end else begin
          beat_d = remaining - BURST_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= M0;
      last_q  <= M1;
      addr_q  <= '0;
      bc_q    <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      bc_q    <= bc_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
    end
  end

  assign s.read       = (state_q == CMD);
  assign s.address    = addr_q;
  assign s.burstcount = bc_q;

  assign m0.waitrequest   = !((state_q == CMD) && (grant_q == M0)) || s.waitrequest;
  assign m1.waitrequest   = !((state_q == CMD) && (grant_q == M1)) || s.waitrequest;
  assign m0.readdatavalid = s.readdatavalid && !empty && (head.id == M0);
  assign m1.readdatavalid = s.readdatavalid && !empty && (head.id == M1);
  assign m0.readdata      = s.readdata;
  assign m1.readdata      = s.readdata;

  assign err_o = err_q;
endmodule
